// File: rtl/ext_pkg.sv
// ----------------------------------------------------------------------------
// ext_pkg -- shared types and constants for the immediate extension unit.
//   ext_op_e : 2-bit extension mode select (zero, sign, load-upper, branch)
//   IMM_W    : width of the immediate field
//   WORD_W   : width of the extended result
// ----------------------------------------------------------------------------
package ext_pkg;

   localparam int IMM_W  = 16;
   localparam int WORD_W = 32;
   localparam int PAD_W  = WORD_W - IMM_W;

   typedef enum logic [1:0] {
      EXT_ZERO = 2'd0,
      EXT_SIGN = 2'd1,
      EXT_LUI  = 2'd2,
      EXT_BR   = 2'd3
   } ext_op_e;

endpackage : ext_pkg

// File: rtl/ext_if.sv
// ----------------------------------------------------------------------------
// ext_if -- request/result bundle of the immediate extension unit.
//   Imm16     : immediate field to extend          (master -> slave)
//   ExtOp     : extension mode select              (master -> slave)
//   in_valid  : Imm16/ExtOp valid this cycle       (master -> slave)
//   Imm32     : registered extended result         (slave -> master)
//   out_valid : Imm32 holds a new result this cycle (slave -> master)
// ----------------------------------------------------------------------------
interface ext_if;
   import ext_pkg::*;

   logic [IMM_W-1:0]  Imm16;
   ext_op_e           ExtOp;
   logic              in_valid;
   logic [WORD_W-1:0] Imm32;
   logic              out_valid;

   modport master (
      output Imm16, ExtOp, in_valid,
      input  Imm32, out_valid
   );

   modport slave (
      input  Imm16, ExtOp, in_valid,
      output Imm32, out_valid
   );

endinterface : ext_if

// File: rtl/ext_core.sv
// ----------------------------------------------------------------------------
// ext_core -- combinational extension mux.
//   imm16  : immediate field
//   ext_op : extension mode
//   result : extended 32-bit word
// Optional feature macro: EXT_BRANCH_SHIFT_EN. When defined, EXT_BR yields a
// sign-extended word offset ({sext(imm16), 2'b00}); otherwise EXT_BR behaves
// exactly like EXT_ZERO.
// ----------------------------------------------------------------------------
module ext_core
   import ext_pkg::*;
(
   input  logic [IMM_W-1:0]  imm16,
   input  ext_op_e           ext_op,
   output logic [WORD_W-1:0] result
);

   // NOTE: result gets a default before the case so every path assigns it;
   // otherwise synthesis infers a latch for the unlisted select values.
   always_comb begin
      result = {{PAD_W{1'b0}}, imm16};
      case (ext_op)
         EXT_SIGN: result = {{PAD_W{imm16[IMM_W-1]}}, imm16};
         EXT_LUI:  result = {imm16, {PAD_W{1'b0}}};
`ifdef EXT_BRANCH_SHIFT_EN
         // Word offset: shift left by two, sign bits fill the top 14 bits.
         EXT_BR:   result = {{(PAD_W-2){imm16[IMM_W-1]}}, imm16, 2'b00};
`else
         EXT_BR:   result = {{PAD_W{1'b0}}, imm16};
`endif
         default:  result = {{PAD_W{1'b0}}, imm16};
      endcase
   end

endmodule : ext_core

// File: rtl/ext_unit.sv
// ----------------------------------------------------------------------------
// ext_unit -- registered immediate extension unit, one-cycle latency.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset (Imm32 <= RESET_VAL, out_valid <= 0)
//   bus   : ext_if.slave (Imm16, ExtOp, in_valid in; Imm32, out_valid out)
// Optional feature macro: EXT_BRANCH_SHIFT_EN (see ext_core).
// A valid input updates Imm32 and pulses out_valid on the next edge; an idle
// cycle holds Imm32 and drops out_valid. No backpressure.
// ----------------------------------------------------------------------------
module ext_unit
   import ext_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_VAL = 32'h0000_0000
) (
   input  logic clk,
   input  logic rst_n,
   ext_if.slave bus
);

   logic [WORD_W-1:0] core_result;
   logic [WORD_W-1:0] imm32_d, imm32_q;
   logic              out_valid_d, out_valid_q;

   ext_core u_core (
      .imm16  (bus.Imm16),
      .ext_op (bus.ExtOp),
      .result (core_result)
   );

   always_comb begin
      imm32_d     = bus.in_valid ? core_result : imm32_q;
      out_valid_d = bus.in_valid;
   end

   // NOTE: non-blocking assignments for all flops so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imm32_q     <= RESET_VAL;
         out_valid_q <= 1'b0;
      end else begin
         imm32_q     <= imm32_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.Imm32     = imm32_q;
   assign bus.out_valid = out_valid_q;

endmodule : ext_unit

// File: tb/tb_ext_unit.sv
// ----------------------------------------------------------------------------
// tb_ext_unit -- scoreboard bench for ext_unit. Stimulus pushes the expected
// word and the cycle it must appear in; a negedge monitor pops and compares
// whenever out_valid is high. Expected words are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_ext_unit;
   import ext_pkg::*;

   localparam logic [31:0] RST_VAL = 32'hA5A5_0F0F;

   typedef struct {
      logic [31:0] word;
      int          cyc;
   } exp_t;

   typedef struct {
      ext_op_e     op;
      logic [15:0] imm;
      logic [31:0] word;
   } vec_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   failures;
   exp_t sb[$];

   ext_if bus ();

   ext_unit #(.RESET_VAL(RST_VAL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every result must match the head of the scoreboard both in
   // value and in the cycle it was promised for.
   always @(negedge clk) begin
      if (bus.out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out_valid actual=%h expected=none (t=%0t)", bus.Imm32, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result_value", bus.Imm32, e.word);
            check("result_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic drive(input ext_op_e op, input logic [15:0] imm, input logic [31:0] word);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.ExtOp    = op;
      bus.Imm16    = imm;
      sb.push_back('{word: word, cyc: cyc + 1});
   endtask

   task automatic go_idle();
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   vec_t vecs[10];

   initial begin
      checks   = 0;
      failures = 0;

      vecs[0] = '{EXT_SIGN, 16'h8001, 32'hFFFF_8001};
      vecs[1] = '{EXT_SIGN, 16'h7FFF, 32'h0000_7FFF};
      vecs[2] = '{EXT_ZERO, 16'hFFFF, 32'h0000_FFFF};
`ifdef EXT_BRANCH_SHIFT_EN
      vecs[3] = '{EXT_BR,   16'hFFFF, 32'hFFFF_FFFC};
      vecs[4] = '{EXT_BR,   16'h0001, 32'h0000_0004};
      vecs[9] = '{EXT_BR,   16'h4000, 32'h0001_0000};
`else
      vecs[3] = '{EXT_BR,   16'hFFFF, 32'h0000_FFFF};
      vecs[4] = '{EXT_BR,   16'h0001, 32'h0000_0001};
      vecs[9] = '{EXT_BR,   16'h4000, 32'h0000_4000};
`endif
      vecs[5] = '{EXT_LUI,  16'hFFFF, 32'hFFFF_0000};
      vecs[6] = '{EXT_SIGN, 16'h0000, 32'h0000_0000};
      vecs[7] = '{EXT_ZERO, 16'h1234, 32'h0000_1234};
      vecs[8] = '{EXT_SIGN, 16'h9ABC, 32'hFFFF_9ABC};

      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.ExtOp    = EXT_ZERO;
      bus.Imm16    = 16'h0000;

      // Reset state, well before release.
      #50;
      check("reset_imm32", bus.Imm32, RST_VAL);
      check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);

      // Reset release at 100 ns with a load-upper request ready.
      #50;
      rst_n        = 1'b1;
      bus.in_valid = 1'b1;
      bus.ExtOp    = EXT_LUI;
      bus.Imm16    = 16'h0004;
      sb.push_back('{word: 32'h0004_0000, cyc: cyc + 1});

      // Directed modes, back to back.
      for (int i = 0; i < 7; i++) drive(vecs[i].op, vecs[i].imm, vecs[i].word);

      // Four-deep stream, then idle: Imm32 holds the last value.
      drive(EXT_ZERO, 16'h1234, 32'h0000_1234);
      drive(EXT_SIGN, 16'h9ABC, 32'hFFFF_9ABC);
      drive(EXT_LUI,  16'h00FF, 32'h00FF_0000);
      drive(vecs[9].op, vecs[9].imm, vecs[9].word);
      go_idle();
      @(posedge clk);
      #1;
      check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("idle_hold_imm32", bus.Imm32, vecs[9].word);
      @(posedge clk);
      #1;
      check("idle2_hold_imm32", bus.Imm32, vecs[9].word);

      // Async reset between edges with a request pending: no result for it.
      bus.in_valid = 1'b1;
      bus.ExtOp    = EXT_SIGN;
      bus.Imm16    = 16'h8001;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_imm32", bus.Imm32, RST_VAL);
      check("async_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      check("post_reset_imm32", bus.Imm32, RST_VAL);

      // Normal operation after the reset pulse.
      drive(vecs[7].op, vecs[7].imm, vecs[7].word);
      drive(vecs[8].op, vecs[8].imm, vecs[8].word);
      go_idle();

      // Drain the scoreboard with a bounded wait.
      for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_ext_unit

// File: doc/ext_unit.md
EXT_UNIT -- requirements
Module: ext_unit

Interface
- REQ-001 Parameter: RESET_VAL, default 32'h0000_0000; value loaded into Imm32 on reset.
- REQ-002 Port: clk, input, 1, sole clock; all state updates on its rising edge.
- REQ-003 Port: rst_n, input, 1, reset; asynchronous, active-low.
- REQ-004 Port: Imm16, input, 16, immediate field to extend.
- REQ-005 Port: ExtOp, input, 2, extension mode select.
- REQ-006 Port: in_valid, input, 1, Imm16/ExtOp are valid this cycle.
- REQ-007 Port: Imm32, output, 32, registered extended result.
- REQ-008 Port: out_valid, output, 1, Imm32 holds a new result this cycle.

Function
- REQ-009 ExtOp=0 (zero-extend): result = {16'h0000, Imm16}.
- REQ-010 ExtOp=1 (sign-extend): result = {{16{Imm16[15]}}, Imm16}.
- REQ-011 ExtOp=2 (load-upper): result = {Imm16, 16'h0000}.
- REQ-012 ExtOp=3 (branch offset, when compiled in): result = {{14{Imm16[15]}}, Imm16, 2'b00}.
- REQ-013 Latency is exactly one clock: a cycle with in_valid=1 updates Imm32 and sets out_valid=1 on the next rising edge.
- REQ-014 A cycle with in_valid=0 holds Imm32 at its previous value and clears out_valid to 0 on the next edge.
- REQ-015 Back-to-back valid inputs produce back-to-back results with no bubbles; no backpressure exists.
- REQ-016 The result is purely a function of the Imm16/ExtOp values sampled in the same cycle; no other state is kept.
- REQ-017 No arithmetic overflow is possible; all bits beyond the 32-bit result are discarded.

Reset
- REQ-018 While rst_n=0, Imm32=RESET_VAL and out_valid=0 immediately, independent of clk.
- REQ-019 The first edge after rst_n deasserts samples inputs normally.
- REQ-020 Reset asserted mid-stream discards any pending result; no out_valid pulse is produced for the interrupted input.

Configuration
- REQ-021 Macro EXT_BRANCH_SHIFT_EN: when defined, ExtOp=3 selects the REQ-012 branch-offset mode.
- REQ-022 When EXT_BRANCH_SHIFT_EN is undefined, ExtOp=3 produces zero-extension, identical to ExtOp=0.

Structure
- REQ-023 A shared package ext_pkg holds the 2-bit ExtOp enum (EXT_ZERO=0, EXT_SIGN=1, EXT_LUI=2, EXT_BR=3) and the constants IMM_W=16 and WORD_W=32.
- REQ-024 One combinational sub-module, ext_core (Imm16, ExtOp -> result), holds the mode mux.
- REQ-025 ext_unit registers the ext_core output and in_valid.

Verification
- REQ-026 Reset-release scenario: rst_n=0, then 1 at 100 ns; in_valid=1, ExtOp=2, Imm16=16'h0004 -> next edge: Imm32=32'h0004_0000, out_valid=1.
- REQ-027 Sign-extension scenario: ExtOp=1 with Imm16=16'h8001 -> Imm32=32'hFFFF_8001; ExtOp=1 with Imm16=16'h7FFF -> Imm32=32'h0000_7FFF.
- REQ-028 Zero-extension scenario: ExtOp=0, Imm16=16'hFFFF -> Imm32=32'h0000_FFFF.
- REQ-029 Branch-offset scenario: ExtOp=3, Imm16=16'hFFFF -> Imm32=32'hFFFF_FFFC with EXT_BRANCH_SHIFT_EN defined, and 32'h0000_FFFF without it.
- REQ-030 Stream scenario: four consecutive valid inputs -> four consecutive results with out_valid high. Then in_valid=0 -> out_valid=0 and Imm32 holds the last value.
- REQ-031 Async-reset scenario: rst_n pulsed low between clock edges -> Imm32=RESET_VAL and out_valid=0 before the next edge.
